// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//
// Memory-mapped LED pattern sequencer. A small register file selects one of
// four animation modes (static, rotate, bounce, blink) that advances an 8-bit
// LED pattern once every PERIOD clocks while running.
//
// Optional feature macro: LED_SEQUENCER_PWM_EN
//   When defined, adds an 8-bit duty register (written at address 3) and a
//   free-running 8-bit pwm counter that gate the LED drive for dimming.
//
// Parameters
//   DIV_W         width of the step divider and the PERIOD register
//   RESET_PERIOD  PERIOD value loaded by reset, in clocks
//
// Ports
//   clk         single clock, all logic on the rising edge
//   reset_n     synchronous active-low reset
//   address     register select (0 CTRL, 1 PATTERN, 2 PERIOD, 3 STATUS)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data of the selected register
//   out_port    LED drive
// ---------------------------------------------------------------------------
module led_sequencer #(
  parameter int DIV_W        = 24,
  parameter int RESET_PERIOD = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  state_t           state;
  logic [1:0]       mode;
  logic [7:0]       pattern;
  logic             dir;        // 0 = moving left, 1 = moving right
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] count;

  logic             write_en;
  logic [DIV_W-1:0] period_m1;
  logic             step_due;
  logic [7:0]       step_pattern;
  logic             step_dir;
  logic [7:0]       duty_view;
  logic [7:0]       pwm_mask;
  logic             unused_writedata;

`ifdef LED_SEQUENCER_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;
`endif

  assign write_en = chipselect & ~write_n;

  // A PERIOD of zero behaves as one, so the terminal count is clamped at 0.
  assign period_m1 = (period == '0) ? '0 : period - DIV_W'(1);

  // Using >= rather than == lets a PERIOD shrink below the running count
  // step and wrap on the very next cycle instead of counting past the end.
  assign step_due = (state == RUN) && (count >= period_m1);

  // Next pattern/direction if a step were to happen this cycle, under the
  // current mode. A zero pattern naturally stays zero under shifts/rotates.
  always_comb begin
    step_pattern = pattern;
    step_dir     = dir;
    case (mode)
      MODE_STATIC: step_pattern = pattern;
      MODE_ROTATE: step_pattern = {pattern[6:0], pattern[7]};
      MODE_BOUNCE: begin
        if (!dir) begin
          if (pattern[7]) begin
            step_dir     = 1'b1;
            step_pattern = pattern >> 1;
          end else begin
            step_pattern = pattern << 1;
          end
        end else begin
          if (pattern[0]) begin
            step_dir     = 1'b0;
            step_pattern = pattern << 1;
          end else begin
            step_pattern = pattern >> 1;
          end
        end
      end
      MODE_BLINK:  step_pattern = ~pattern;
      default:     step_pattern = pattern;
    endcase
  end

  // Register file, run/idle FSM, step divider and pattern state in one block.
  // Reset is checked first so it beats any write or step on the same edge;
  // register writes come after the divider logic so a PATTERN write landing
  // on a step cycle overrides the stepped value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      mode    <= MODE_STATIC;
      pattern <= 8'h01;
      dir     <= 1'b0;
      period  <= DIV_W'(RESET_PERIOD);
      count   <= '0;
`ifdef LED_SEQUENCER_PWM_EN
      duty    <= 8'hFF;
      pwm_cnt <= 8'h00;
`endif
    end else begin
      if (state == RUN) begin
        if (step_due) begin
          count   <= '0;
          pattern <= step_pattern;
          dir     <= step_dir;
        end else begin
          count   <= count + DIV_W'(1);
        end
      end else begin
        count <= '0;
      end

      if (write_en) begin
        case (address)
          ADDR_CTRL: begin
            state <= writedata[0] ? RUN : IDLE;
            mode  <= writedata[2:1];
            // Only a write that keeps an already running sequencer running
            // preserves the count; entering RUN always starts from zero.
            if (!(state == RUN && writedata[0])) begin
              count <= '0;
            end
          end
          ADDR_PATTERN: begin
            pattern <= writedata[7:0];
            dir     <= 1'b0;
            count   <= '0;
          end
          ADDR_PERIOD: begin
            period <= writedata[DIV_W-1:0];
          end
          ADDR_STATUS: begin
`ifdef LED_SEQUENCER_PWM_EN
            duty <= writedata[7:0];
`endif
          end
          default: ;
        endcase
      end

`ifdef LED_SEQUENCER_PWM_EN
      pwm_cnt <= pwm_cnt + 8'd1;
`endif
    end
  end

  // Duty as seen by STATUS and the gating mask applied to the LED drive.
  // Duty 0xFF is forced fully on, since pwm_cnt < 0xFF misses one slot.
`ifdef LED_SEQUENCER_PWM_EN
  assign duty_view = duty;
  assign pwm_mask  = {8{(pwm_cnt < duty) || (duty == 8'hFF)}};
`else
  assign duty_view = 8'h00;
  assign pwm_mask  = 8'hFF;
`endif

  assign out_port = pattern & pwm_mask;

  // Combinational read mux; bits not backed by a register read as zero.
  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_CTRL:    readdata = {29'h0, mode, (state == RUN)};
      ADDR_PATTERN: readdata = {24'h0, pattern};
      ADDR_PERIOD:  readdata = 32'(period);
      ADDR_STATUS:  readdata = {8'h00, duty_view, 7'h00, dir, pattern};
      default:      readdata = 32'h0;
    endcase
  end

  // Not every writedata bit lands in a register.
  assign unused_writedata = ^writedata;

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
//
// Self-checking bench for led_sequencer. A behavioural model of the register
// map and animation rules is updated on every rising edge from the same bus
// inputs as the DUT; a compare process checks out_port and readdata against
// it on every falling edge. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // -------------------------------------------------------------------------
  // Behavioural model state
  // -------------------------------------------------------------------------
  bit model_valid = 1'b0;
  bit m_run;
  int m_mode;
  int m_pat;
  int m_dir;
  int m_period;
  int m_elapsed;
  int m_duty;
  int m_pwm;

  // One animation step expressed with plain arithmetic on the pattern value.
  function automatic void advance(input int mode, input int pat, input int dir,
                                  output int npat, output int ndir);
    npat = pat;
    ndir = dir;
    case (mode)
      1: npat = ((pat * 2) % 256) + (pat / 128);
      2: begin
        if (dir == 0) begin
          if (pat >= 128) begin ndir = 1; npat = pat / 2; end
          else npat = (pat * 2) % 256;
        end else begin
          if (pat % 2 == 1) begin ndir = 0; npat = (pat * 2) % 256; end
          else npat = pat / 2;
        end
      end
      3: npat = 255 - pat;
      default: npat = pat;
    endcase
  endfunction

  function automatic int duty_seen();
`ifdef LED_SEQUENCER_PWM_EN
    return m_duty;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_out();
`ifdef LED_SEQUENCER_PWM_EN
    if (m_duty == 255 || m_pwm < m_duty) return 32'(m_pat);
    return 32'h0;
`else
    return 32'(m_pat);
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_mode * 2 + int'(m_run));
      2'd1:    return 32'(m_pat);
      2'd2:    return 32'(m_period);
      default: return 32'(m_pat + m_dir * 256 + duty_seen() * 65536);
    endcase
  endfunction

  // Model update on every rising edge from the bus inputs seen there.
  initial begin
    bit n_run;
    bit stepping;
    int eff, n_mode, n_pat, n_dir, n_period, n_el, n_duty;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_run = 0; m_mode = 0; m_pat = 1; m_dir = 0;
        m_period = 5000000; m_elapsed = 0; m_duty = 255; m_pwm = 0;
        model_valid = 1'b1;
      end else if (model_valid) begin
        eff      = (m_period == 0) ? 1 : m_period;
        stepping = m_run && (m_elapsed + 1 >= eff);
        n_run = m_run; n_mode = m_mode; n_pat = m_pat; n_dir = m_dir;
        n_period = m_period; n_duty = m_duty;
        n_el = !m_run ? 0 : (stepping ? 0 : m_elapsed + 1);
        if (stepping) advance(m_mode, m_pat, m_dir, n_pat, n_dir);
        if (chipselect && !write_n) begin
          case (address)
            2'd0: begin
              n_run  = writedata[0];
              n_mode = int'(writedata[2:1]);
              if (!m_run || !writedata[0]) n_el = 0;
            end
            2'd1: begin
              n_pat = int'(writedata[7:0]); n_dir = 0; n_el = 0;
            end
            2'd2: n_period = int'(writedata[23:0]);
            default: begin
`ifdef LED_SEQUENCER_PWM_EN
              n_duty = int'(writedata[7:0]);
`endif
            end
          endcase
        end
        m_run = n_run; m_mode = n_mode; m_pat = n_pat; m_dir = n_dir;
        m_period = n_period; m_elapsed = n_el; m_duty = n_duty;
        m_pwm = (m_pwm + 1) % 256;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Checking helpers
  // -------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        checkOutput("model_out_port", {24'h0, out_port}, exp_out());
        checkOutput("model_readdata", readdata, exp_read(address));
      end
    end
  end

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One zero-wait-state register write, captured on the next rising edge.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequences
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    int on_cnt, off_cnt;

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;

    // Reset state
    step();
    step();
    reset_n = 1'b1;
    checkOutput("reset_out_port", {24'h0, out_port}, 32'h01);
    read_reg(2'd0, rd);
    checkOutput("reset_ctrl", rd, 32'h0);
    read_reg(2'd2, rd);
    checkOutput("reset_period", rd, 32'd5000000);
    read_reg(2'd3, rd);
`ifdef LED_SEQUENCER_PWM_EN
    checkOutput("reset_status", rd, 32'h00FF0001);
`else
    checkOutput("reset_status", rd, 32'h00000001);
`endif

    // Rotate, PERIOD=4: first step 4 clocks after the run write
    applyStimulus(2'd1, 32'h81);
    applyStimulus(2'd2, 32'd4);
    applyStimulus(2'd0, 32'h3);
    repeat (3) step();
    checkOutput("rotate_before_step", {24'h0, out_port}, 32'h81);
    step();
    checkOutput("rotate_step1", {24'h0, out_port}, 32'h03);
    repeat (4) step();
    checkOutput("rotate_step2", {24'h0, out_port}, 32'h06);
    read_reg(2'd0, rd);
    checkOutput("rotate_ctrl_read", rd, 32'h3);

    // Bounce, PERIOD=1
    applyStimulus(2'd0, 32'h0);
    applyStimulus(2'd1, 32'h40);
    applyStimulus(2'd2, 32'd1);
    applyStimulus(2'd0, 32'h5);
    step();
    checkOutput("bounce_1", {24'h0, out_port}, 32'h80);
    step();
    checkOutput("bounce_2", {24'h0, out_port}, 32'h40);
    read_reg(2'd3, rd);
    checkOutput("bounce_dir_right", {31'h0, rd[8]}, 32'h1);
    step();
    checkOutput("bounce_3", {24'h0, out_port}, 32'h20);

    // Zero pattern stays zero in rotate and bounce
    applyStimulus(2'd0, 32'h0);
    applyStimulus(2'd1, 32'h00);
    applyStimulus(2'd0, 32'h3);
    repeat (3) step();
    checkOutput("zero_rotate", {24'h0, out_port}, 32'h00);
    applyStimulus(2'd0, 32'h5);
    repeat (3) step();
    checkOutput("zero_bounce", {24'h0, out_port}, 32'h00);

    // PERIOD=0 behaves as 1; PATTERN write on a step cycle wins
    applyStimulus(2'd0, 32'h0);
    applyStimulus(2'd2, 32'd0);
    applyStimulus(2'd1, 32'h01);
    applyStimulus(2'd0, 32'h3);
    step();
    checkOutput("zero_period_step", {24'h0, out_port}, 32'h02);
    step();
    applyStimulus(2'd1, 32'h0F);
    checkOutput("collision_keep", {24'h0, out_port}, 32'h0F);
    step();
    checkOutput("collision_next", {24'h0, out_port}, 32'h1E);

    // PERIOD shrink below the running count steps on the next cycle
    applyStimulus(2'd0, 32'h0);
    applyStimulus(2'd1, 32'h01);
    applyStimulus(2'd2, 32'd8);
    applyStimulus(2'd0, 32'h3);
    repeat (5) step();
    applyStimulus(2'd2, 32'd2);
    checkOutput("period_change_hold", {24'h0, out_port}, 32'h01);
    step();
    checkOutput("period_change_step", {24'h0, out_port}, 32'h02);
    repeat (2) step();
    checkOutput("period_change_next", {24'h0, out_port}, 32'h04);

    // Reset mid-run in blink mode
    applyStimulus(2'd0, 32'h0);
    applyStimulus(2'd2, 32'd2);
    applyStimulus(2'd1, 32'hAA);
    applyStimulus(2'd0, 32'h7);
    step();
    checkOutput("blink_mid_count", {24'h0, out_port}, 32'hAA);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checkOutput("midrun_reset_out", {24'h0, out_port}, 32'h01);
    repeat (6) step();
    checkOutput("midrun_reset_frozen", {24'h0, out_port}, 32'h01);
    read_reg(2'd0, rd);
    checkOutput("midrun_reset_ctrl", rd, 32'h0);

`ifdef LED_SEQUENCER_PWM_EN
    // PWM dimming: duty 0x40 -> on 64 of every 256 clocks; duty 0 -> off
    applyStimulus(2'd1, 32'hFF);
    applyStimulus(2'd3, 32'h40);
    on_cnt  = 0;
    off_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (out_port == 8'hFF) on_cnt++;
      else if (out_port == 8'h00) off_cnt++;
      step();
    end
    checkOutput("pwm_on_count", 32'(on_cnt), 32'd64);
    checkOutput("pwm_total_count", 32'(on_cnt + off_cnt), 32'd256);
    applyStimulus(2'd3, 32'h00);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (out_port != 8'h00) on_cnt++;
      step();
    end
    checkOutput("pwm_duty0_on_count", 32'(on_cnt), 32'd0);
`else
    // Without PWM, STATUS writes are ignored and LEDs follow the pattern
    applyStimulus(2'd1, 32'hFF);
    applyStimulus(2'd3, 32'h40);
    read_reg(2'd3, rd);
    checkOutput("status_write_ignored", rd, 32'h000000FF);
    on_cnt  = 0;
    off_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_port == 8'hFF) on_cnt++;
      step();
    end
    checkOutput("no_pwm_always_on", 32'(on_cnt + off_cnt), 32'd16);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] time limit");
  end

endmodule
